// File: rtl/min_cost_selector_if.sv
// Candidate stream in, min-cost result out; the selector owns the slave view.
interface min_cost_selector_if #(
  parameter int input_size = 8,
  parameter int id_size    = 4,
  parameter int count_size = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [input_size-1:0] in_cost;
  logic [id_size-1:0]    in_id;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [input_size-1:0] out_cost;
  logic [id_size-1:0]    out_id;
  logic                  out_tie;
  logic [count_size-1:0] out_count;

  modport slave (
    input  in_valid, in_cost, in_id, in_last, out_ready,
    output in_ready, out_valid, out_cost, out_id, out_tie, out_count
  );

  modport master (
    output in_valid, in_cost, in_id, in_last, out_ready,
    input  in_ready, out_valid, out_cost, out_id, out_tie, out_count
  );
endinterface

// File: rtl/min_cost_selector.sv
// Streaming min-cost reduction over a frame of (cost, id) beats; earliest
// arrival wins on equal cost and a tie flag reports a repeated minimum.
module min_cost_selector #(
  parameter int input_size = 8,
  parameter int id_size    = 4,
  parameter int count_size = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  min_cost_selector_if.slave    sel_if
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e                state_q;
  logic [input_size-1:0] best_cost_q;
  logic [id_size-1:0]    best_id_q;
  logic                  tie_q;
  logic [count_size-1:0] cnt_q;
  logic                  in_ready_q;
  logic                  out_valid_q;

  logic                  cmp_eq, cmp_lt, cmp_gt;
  logic                  accept;
  logic [count_size-1:0] cnt_d;

  mcs_comparator #(.input_size(input_size)) u_cmp (
    .input1_i  (sel_if.in_cost),
    .input2_i  (best_cost_q),
    .equal_o   (cmp_eq),
    .less_o    (cmp_lt),
    .greater_o (cmp_gt)
  );

  assign accept = sel_if.in_valid && in_ready_q;
  assign cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      best_cost_q <= '0;
      best_id_q   <= '0;
      tie_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          // first beat seeds the running best without a comparison
          if (accept) begin
            best_cost_q <= sel_if.in_cost;
            best_id_q   <= sel_if.in_id;
            tie_q       <= 1'b0;
            cnt_q       <= {{(count_size-1){1'b0}}, 1'b1};
            if (sel_if.in_last) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            if (cmp_lt) begin
              best_cost_q <= sel_if.in_cost;
              best_id_q   <= sel_if.in_id;
              tie_q       <= 1'b0;
            end else if (cmp_eq && !cmp_gt) begin
              tie_q <= 1'b1;
            end
            cnt_q <= cnt_d;
            if (sel_if.in_last) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (sel_if.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // result fields are the running-best registers, frozen while in HOLD
  assign sel_if.in_ready  = in_ready_q;
  assign sel_if.out_valid = out_valid_q;
  assign sel_if.out_cost  = best_cost_q;
  assign sel_if.out_id    = best_id_q;
  assign sel_if.out_tie   = tie_q;
  assign sel_if.out_count = cnt_q;
endmodule

module mcs_comparator #(
  parameter int input_size = 8
) (
  input  logic [input_size-1:0] input1_i,
  input  logic [input_size-1:0] input2_i,
  output logic                  equal_o,
  output logic                  less_o,
  output logic                  greater_o
);
  assign equal_o   = (input1_i == input2_i);
  assign less_o    = (input1_i <  input2_i);
  assign greater_o = (input1_i >  input2_i);
endmodule

// File: tb/tb_min_cost_selector.sv
// Directed and random frames against a queue-based min/tie/count model;
// a second instance with a 2-bit counter shares the stimulus.
module tb_min_cost_selector;
  logic       clk;
  logic       rst_n;
  logic       in_valid, in_last, out_ready;
  logic [7:0] in_cost;
  logic [3:0] in_id;

  int ncmp = 0;
  int nerr = 0;

  int q_cost[$];
  int q_id[$];

  min_cost_selector_if #(.input_size(8), .id_size(4), .count_size(8)) ia ();
  min_cost_selector_if #(.input_size(8), .id_size(4), .count_size(2)) ib ();

  assign ia.in_valid  = in_valid;
  assign ia.in_cost   = in_cost;
  assign ia.in_id     = in_id;
  assign ia.in_last   = in_last;
  assign ia.out_ready = out_ready;
  assign ib.in_valid  = in_valid;
  assign ib.in_cost   = in_cost;
  assign ib.in_id     = in_id;
  assign ib.in_last   = in_last;
  assign ib.out_ready = out_ready;

  min_cost_selector #(.input_size(8), .id_size(4), .count_size(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .sel_if(ia.slave));
  min_cost_selector #(.input_size(8), .id_size(4), .count_size(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .sel_if(ib.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // drive one beat, wait until the DUT shows ready, let the edge accept it
  task automatic send(input int c, input int i, input bit l);
    int g;
    g = 0;
    @(negedge clk);
    in_valid = 1'b1; in_cost = 8'(c); in_id = 4'(i); in_last = l;
    while (ia.in_ready !== 1'b1) begin
      if (g >= 20) begin
        ncmp++; nerr++;
        $error("FAIL ready_timeout: observed in_ready=%b expected 1", ia.in_ready);
        break;
      end
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    q_cost.push_back(c);
    q_id.push_back(i);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // result: minimum cost, first id holding it, tie if the minimum repeats
  task automatic model(output int c, output int i, output int t, output int n);
    int hits;
    c = 1 << 30; i = 0; hits = 0;
    foreach (q_cost[k]) begin
      if (q_cost[k] < c) begin c = q_cost[k]; i = q_id[k]; hits = 1; end
      else if (q_cost[k] == c) hits++;
    end
    t = (hits > 1) ? 1 : 0;
    n = (q_cost.size() > 255) ? 255 : q_cost.size();
  endtask

  // expects the result on the very next cycle after the last beat
  task automatic check_result(input int c, input int i, input int t, input int n);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("out_valid", 32'(ia.out_valid), 1);
    chk("out_cost",  32'(ia.out_cost), 32'(c));
    chk("out_id",    32'(ia.out_id), 32'(i));
    chk("out_tie",   32'(ia.out_tie), 32'(t));
    chk("out_count", 32'(ia.out_count), 32'(n));
    chk("out_count_sat2", 32'(ib.out_count), 32'((n > 3) ? 3 : n));
    chk("in_ready_hold", 32'(ia.in_ready), 0);
    if (out_ready) begin
      @(negedge clk);
      chk("out_valid_after_hs", 32'(ia.out_valid), 0);
      chk("in_ready_after_hs",  32'(ia.in_ready), 1);
    end
    q_cost.delete();
    q_id.delete();
  endtask

  initial begin
    int ec, ei, et, en, len;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_cost = '0; in_id = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(ia.out_valid), 0);
    chk("rst_out_cost",  32'(ia.out_cost), 0);
    chk("rst_out_id",    32'(ia.out_id), 0);
    chk("rst_out_tie",   32'(ia.out_tie), 0);
    chk("rst_out_count", 32'(ia.out_count), 0);
    chk("rst_in_ready",  32'(ia.in_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(ia.in_ready), 1);

    // reset mid-frame after three beats
    send(50, 2, 0); send(30, 3, 0); send(30, 4, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ia.out_valid), 0);
    chk("midrst_out_count", 32'(ia.out_count), 0);
    chk("midrst_in_ready",  32'(ia.in_ready), 0);
    q_cost.delete(); q_id.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_rel_in_ready", 32'(ia.in_ready), 1);
    send(7, 1, 1);
    check_result(7, 1, 0, 1);

    // basic min with a later equal minimum
    send(40, 0, 0); send(12, 1, 0); send(33, 2, 0); send(12, 3, 1);
    check_result(12, 1, 1, 4);

    // a strictly smaller cost clears the tie
    send(5, 0, 0); send(5, 1, 0); send(3, 2, 1);
    check_result(3, 2, 0, 3);

    // backpressure: result held, stray in_valid ignored
    out_ready = 1'b0;
    send(20, 3, 0); send(9, 4, 1);
    check_result(9, 4, 0, 2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) begin in_valid = 1'b1; in_cost = 8'd1; in_id = 4'd7; in_last = 1'b1; end
      else in_valid = 1'b0;
      chk("bp_out_valid", 32'(ia.out_valid), 1);
      chk("bp_out_cost",  32'(ia.out_cost), 9);
      chk("bp_out_id",    32'(ia.out_id), 4);
      chk("bp_out_count", 32'(ia.out_count), 2);
      chk("bp_in_ready",  32'(ia.in_ready), 0);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    chk("bp_still_valid", 32'(ia.out_valid), 1);
    @(negedge clk);
    chk("bp_hs_out_valid", 32'(ia.out_valid), 0);
    chk("bp_hs_in_ready",  32'(ia.in_ready), 1);

    // bubbles and cost extremes
    send(255, 0, 0);
    idle(3);
    send(0, 15, 1);
    check_result(0, 15, 0, 2);
    send(255, 6, 1);
    check_result(255, 6, 0, 1);

    // six equal beats: 2-bit counter saturates at 3
    for (int k = 0; k < 6; k++) send(1, k + 8, k == 5);
    check_result(1, 8, 1, 6);

    // random frames, narrow cost range on odd frames to force ties;
    // the last frame is long enough to saturate the 8-bit counter
    for (int f = 0; f < 20; f++) begin
      len = (f == 19) ? 300 : int'($urandom_range(1, 12));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send(int'($urandom_range(0, (f % 2) ? 7 : 255)), int'($urandom_range(0, 15)), b == len - 1);
      end
      model(ec, ei, et, en);
      check_result(ec, ei, et, en);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/min_cost_selector.md
Name: min_cost_selector

Overview:
- Streaming reduction stage that sits directly downstream of the comparator module in the routing path.
- Accepts a frame of (cost, id) candidates one beat per cycle over a valid/ready handshake. Each incoming cost is compared against the running best using an internal comparator instance; the equal/less/greater results drive the update.
- On the frame's last beat, presents the minimum-cost candidate, a tie flag and the candidate count to the route-select logic.

Parameters:
- input_size, 8, width of cost operands; also passed to the internal comparator instance.
- id_size, 4, width of the candidate port id.
- count_size, 8, width of the candidate counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  candidate beat valid.
- in_ready  output  1  block can accept a beat.
- in_cost  input  input_size  candidate cost, unsigned.
- in_id  input  id_size  candidate port id.
- in_last  input  1  final beat of the frame.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_cost  output  input_size  minimum cost in the frame.
- out_id  output  id_size  id of the selected candidate.
- out_tie  output  1  another candidate matched the final minimum.
- out_count  output  count_size  number of beats in the frame, saturating.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; in_ready=0 while rst_n is low, 1 from the first cycle after release.
  - out_valid=0, out_cost=0, out_id=0, out_tie=0, out_count=0.
- A beat is accepted when in_valid && in_ready at the clock edge.
- Internal comparator: input1=in_cost, input2=best_cost (registered).
- States:
  - IDLE: in_ready=1. An accepted beat loads best_cost=in_cost, best_id=in_id, tie=0, count=1. If in_last, go to HOLD; otherwise go to ACCUM. No comparison is used for the first beat.
  - ACCUM: in_ready=1. On each accepted beat:
    - less: best_cost/best_id replaced by the incoming values, tie=0.
    - equal: best unchanged (earliest arrival wins), tie=1.
    - greater: no change to best or tie.
    - count increments on every accepted beat and saturates at 2^count_size-1.
    - If in_last, go to HOLD. The last beat's comparison is included in the result.
  - HOLD: in_ready=0, out_valid=1. Outputs reflect the final best, tie and count.
- Latency: out_valid rises on the cycle after the in_last beat is accepted.
- Output stability: outputs are held stable while out_valid && !out_ready.
- Result handshake: on out_valid && out_ready, go to IDLE. out_valid=0 the following cycle. out_cost, out_id, out_tie and out_count keep their last values; they are don't-care when out_valid=0.
- No frame overlap: a new frame cannot begin until the result is taken. Back-to-back maximum throughput is one frame per (N+1) cycles.
- in_valid=0 inside ACCUM: idle cycle, state retained indefinitely.
- Single-beat frame (in_last on the first beat): result is that beat, tie=0, count=1.
- Asserting rst_n low mid-frame or in HOLD discards the partial result; the block returns to the IDLE reset values immediately.
- Cost arithmetic is unsigned; no cost arithmetic is performed beyond comparison.
- Input fields are sampled only on accepted beats; values on non-accepted cycles are ignored.

Test Plan:
- Reset check: hold rst_n=0 mid-frame after 3 beats, then release. Required: out_valid=0 and out_count=0 while in reset, in_ready=1 the cycle after release, and a new frame (7,id1,last) gives cost=7, id=1, count=1.
- Basic min: beats (cost,id) = (40,0),(12,1),(33,2),(12,3,last) with out_ready=1. Required: out_valid one cycle after the last beat with out_cost=12, out_id=1, out_tie=1, out_count=4. in_ready=0 during HOLD.
- Tie clearing: beats (5,0),(5,1),(3,2,last). Required: out_cost=3, out_id=2, out_tie=0, count=3.
- Backpressure: a frame ending in (9,4,last) with out_ready=0 for 5 cycles. Required: out_valid and all outputs stable, in_ready=0, and an in_valid pulse is not accepted. Once out_ready=1: one-cycle handshake, then IDLE.
- Bubbles and extremes: beats (255,0), gap of 3 cycles with in_valid=0, then (0,15,last). Required: out_cost=0, out_id=15, count=2. Single-beat frame (255,6,last): out_cost=255, out_id=6, tie=0, count=1.
- Counter saturation with count_size=2: a frame of 6 beats of equal cost 1. Required: out_count=3, out_id=first id, out_tie=1.
